// File: rtl/apb3_mem_completer.sv
// APB3 completer backed by a word-addressed memory with configurable wait states.
// Outputs are registered; bus protocol violations set a sticky flag.
module apb3_mem_completer #(
   parameter int AddressWidth  = 20,
   parameter int DataWidth     = 32,
   parameter int MemDepthWords = 256,
   parameter int WaitStates    = 0
) (
   input  logic                    pclk,
   input  logic                    presetn,
   input  logic [AddressWidth-1:0] paddr,
   input  logic                    pselx,
   input  logic                    penable,
   input  logic                    pwrite,
   input  logic [DataWidth-1:0]    pwdata,
   output logic                    pready,
   output logic [DataWidth-1:0]    prdata,
   output logic                    pslverr,
   output logic                    protocol_error
);

   localparam int OFFS = $clog2(DataWidth / 8);
   localparam int IDXW = (MemDepthWords > 1) ? $clog2(MemDepthWords) : 1;
   localparam logic [AddressWidth-1:0] DEPTH = AddressWidth'(MemDepthWords);

   typedef enum logic {S_IDLE, S_ACCESS} state_e;

   state_e                  state_q, state_d;
   logic [AddressWidth-1:0] addr_q, addr_d;
   logic                    wr_q, wr_d;
   logic [DataWidth-1:0]    wdata_q, wdata_d;
   logic [3:0]              cnt_q, cnt_d;
   logic                    pready_q, pready_d;
   logic [DataWidth-1:0]    prdata_q, prdata_d;
   logic                    pslverr_q, pslverr_d;
   logic                    perr_q, perr_d;
   logic                    mem_we;
   logic                    done_next;

   logic [DataWidth-1:0]    mem_q [MemDepthWords];

   logic [AddressWidth-1:0] widx_q, widx_d;
   logic                    rng_q, rng_d;

   assign widx_q = addr_q >> OFFS;
   assign widx_d = addr_d >> OFFS;
   assign rng_q  = widx_q < DEPTH;
   assign rng_d  = widx_d < DEPTH;

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      wr_d    = wr_q;
      wdata_d = wdata_q;
      cnt_d   = cnt_q;
      perr_d  = perr_q;
      mem_we  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (pselx && !penable) begin
               state_d = S_ACCESS;
               addr_d  = paddr;
               wr_d    = pwrite;
               wdata_d = pwdata;
               cnt_d   = 4'(WaitStates);
            end else if (pselx && penable) begin
               perr_d = 1'b1;
            end
         end
         S_ACCESS: begin
            if (!(pselx && penable)) begin
               perr_d  = 1'b1;
               state_d = S_IDLE;
            end else if (cnt_q == 4'd0) begin
               mem_we  = wr_q && rng_q;
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase
      // Response registers are loaded one edge early so the completion cycle sees them.
      done_next = (state_d == S_ACCESS) && (cnt_d == 4'd0);
      pready_d  = done_next;
      pslverr_d = done_next && !rng_d;
      prdata_d  = (done_next && !wr_d && rng_d) ? mem_q[widx_d[IDXW-1:0]] : '0;
   end

   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         state_q   <= S_IDLE;
         addr_q    <= '0;
         wr_q      <= 1'b0;
         wdata_q   <= '0;
         cnt_q     <= '0;
         pready_q  <= 1'b0;
         prdata_q  <= '0;
         pslverr_q <= 1'b0;
         perr_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         wr_q      <= wr_d;
         wdata_q   <= wdata_d;
         cnt_q     <= cnt_d;
         pready_q  <= pready_d;
         prdata_q  <= prdata_d;
         pslverr_q <= pslverr_d;
         perr_q    <= perr_d;
      end
   end

   // Storage is deliberately not reset.
   always_ff @(posedge pclk) begin
      if (mem_we) mem_q[widx_q[IDXW-1:0]] <= wdata_q;
   end

   assign pready         = pready_q;
   assign prdata         = prdata_q;
   assign pslverr        = pslverr_q;
   assign protocol_error = perr_q;

endmodule

// File: tb/tb_apb3_mem_completer.sv
// Bench: two completers (0 and 3 wait states) on a shared bus, checked against an array model.
module tb_apb3_mem_completer;

   localparam int WS [2] = '{0, 3};

   logic        pclk = 1'b0;
   logic        presetn = 1'b0;
   logic [19:0] paddr = '0;
   logic [1:0]  psel = '0;
   logic        penable = 1'b0;
   logic        pwrite = 1'b0;
   logic [31:0] pwdata = '0;
   logic [1:0]        pready_v, pslverr_v, perr_v;
   logic [1:0][31:0]  prdata_v;

   logic [31:0] mem_m [2][256];
   int nchk = 0;
   int nerr = 0;

   always #5 pclk = ~pclk;

   apb3_mem_completer #(.AddressWidth(20), .DataWidth(32), .MemDepthWords(256), .WaitStates(0)) u_dut0 (
      .pclk(pclk), .presetn(presetn), .paddr(paddr), .pselx(psel[0]), .penable(penable),
      .pwrite(pwrite), .pwdata(pwdata), .pready(pready_v[0]), .prdata(prdata_v[0]),
      .pslverr(pslverr_v[0]), .protocol_error(perr_v[0]));

   apb3_mem_completer #(.AddressWidth(20), .DataWidth(32), .MemDepthWords(256), .WaitStates(3)) u_dut3 (
      .pclk(pclk), .presetn(presetn), .paddr(paddr), .pselx(psel[1]), .penable(penable),
      .pwrite(pwrite), .pwdata(pwdata), .pready(pready_v[1]), .prdata(prdata_v[1]),
      .pslverr(pslverr_v[1]), .protocol_error(perr_v[1]));

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge pclk);
      #1;
   endtask

   // One full transfer; the next call starts its setup phase on the very next cycle.
   task automatic xfer(input int d, input logic [19:0] a, input logic w, input logic [31:0] wd,
                       output logic [31:0] rd, output logic er, output int waits);
      psel[d] = 1'b1; penable = 1'b0; paddr = a; pwrite = w; pwdata = wd;
      tick();
      penable = 1'b1;
      paddr = 20'($urandom); pwdata = $urandom; pwrite = 1'($urandom);
      waits = 0;
      while (!pready_v[d] && waits < 20) begin
         tick();
         waits++;
      end
      rd = prdata_v[d];
      er = pslverr_v[d];
      tick();
      psel[d] = 1'b0; penable = 1'b0;
      chk("pready_drop", {63'd0, pready_v[d]}, 64'd0);
   endtask

   task automatic do_op(input int d, input logic [19:0] a, input logic w, input logic [31:0] wd);
      logic [31:0] rd, exp;
      logic er, inr;
      int wt;
      inr = (a >> 2) < 20'd256;
      exp = (inr) ? mem_m[d][a[9:2]] : 32'd0;
      xfer(d, a, w, wd, rd, er, wt);
      chk("wait_cycles", 64'(wt), 64'(WS[d]));
      chk("pslverr", {63'd0, er}, {63'd0, !inr});
      if (!w) chk("prdata", {32'd0, rd}, {32'd0, exp});
      if (w && inr) mem_m[d][a[9:2]] = wd;
   endtask

   initial begin
      #1;
      for (int d = 0; d < 2; d++) begin
         chk("rst_pready", {63'd0, pready_v[d]}, 64'd0);
         chk("rst_prdata", {32'd0, prdata_v[d]}, 64'd0);
         chk("rst_pslverr", {63'd0, pslverr_v[d]}, 64'd0);
         chk("rst_perr", {63'd0, perr_v[d]}, 64'd0);
      end
      tick(); tick();
      presetn = 1'b1;
      tick();

      for (int d = 0; d < 2; d++)
         for (int i = 0; i < 256; i++) do_op(d, 20'(i * 4), 1'b1, $urandom);

      do_op(0, 20'h10, 1'b1, 32'hDEADBEEF);
      do_op(0, 20'h10, 1'b0, 32'h0);
      do_op(1, 20'h0, 1'b1, 32'h12345678);
      do_op(1, 20'h0, 1'b0, 32'h0);
      for (int d = 0; d < 2; d++) begin
         do_op(d, 20'h400, 1'b1, 32'hFFFF);
         do_op(d, 20'h400, 1'b0, 32'h0);
         do_op(d, 20'h3FC, 1'b0, 32'h0);
         do_op(d, 20'h4, 1'b1, 32'h1);
         do_op(d, 20'h4, 1'b0, 32'h0);
         do_op(d, 20'h7, 1'b0, 32'h0);
      end

      for (int i = 0; i < 400; i++) begin
         int d;
         logic [19:0] a;
         d = int'($urandom_range(0, 1));
         a = ($urandom_range(0, 9) == 0) ? 20'($urandom) : 20'($urandom_range(0, 'h4FF));
         do_op(d, a, 1'($urandom), $urandom);
      end

      // Select dropped in the 2nd access cycle of a 3-wait-state write.
      psel[1] = 1'b1; penable = 1'b0; paddr = 20'h8; pwrite = 1'b1; pwdata = 32'hAA;
      tick();
      penable = 1'b1;
      tick();
      psel[1] = 1'b0; penable = 1'b0;
      tick();
      chk("viol_perr", {63'd0, perr_v[1]}, 64'd1);
      chk("viol_pready", {63'd0, pready_v[1]}, 64'd0);
      do_op(1, 20'h8, 1'b0, 32'h0);
      chk("viol_sticky", {63'd0, perr_v[1]}, 64'd1);

      // Access phase without setup while idle.
      psel[0] = 1'b1; penable = 1'b1;
      tick();
      psel[0] = 1'b0; penable = 1'b0;
      tick();
      chk("idle_viol_perr", {63'd0, perr_v[0]}, 64'd1);
      chk("idle_viol_pready", {63'd0, pready_v[0]}, 64'd0);

      // Reset during a 3-wait-state write to 0xC.
      psel[1] = 1'b1; penable = 1'b0; paddr = 20'hC; pwrite = 1'b1; pwdata = ~mem_m[1][3];
      tick();
      penable = 1'b1;
      tick();
      #2 presetn = 1'b0;
      #1;
      chk("rst_mid_pready", {63'd0, pready_v[1]}, 64'd0);
      chk("rst_mid_pslverr", {63'd0, pslverr_v[1]}, 64'd0);
      chk("rst_mid_prdata", {32'd0, prdata_v[1]}, 64'd0);
      chk("rst_mid_perr1", {63'd0, perr_v[1]}, 64'd0);
      chk("rst_mid_perr0", {63'd0, perr_v[0]}, 64'd0);
      psel[1] = 1'b0; penable = 1'b0;
      tick();
      presetn = 1'b1;
      tick();
      do_op(1, 20'hC, 1'b0, 32'h0);

      // Reset while a zero-wait read is presenting its data.
      psel[0] = 1'b1; penable = 1'b0; paddr = 20'h10; pwrite = 1'b0;
      tick();
      penable = 1'b1;
      chk("rd_pready", {63'd0, pready_v[0]}, 64'd1);
      chk("rd_prdata", {32'd0, prdata_v[0]}, {32'd0, mem_m[0][4]});
      #2 presetn = 1'b0;
      #1;
      chk("rst_rd_pready", {63'd0, pready_v[0]}, 64'd0);
      chk("rst_rd_prdata", {32'd0, prdata_v[0]}, 64'd0);
      psel[0] = 1'b0; penable = 1'b0;
      tick();
      presetn = 1'b1;
      tick();

      for (int i = 0; i < 50; i++)
         do_op(int'($urandom_range(0, 1)), 20'($urandom_range(0, 'h4FF)), 1'($urandom), $urandom);

      $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
      $finish;
   end

endmodule

// File: doc/apb3_mem_completer.md
Name: apb3_mem_completer

Overview:
- Synthesizable APB3 completer (subordinate) with a word-addressed memory array, sitting directly downstream of the Renode APB3 requester on the same renode_apb3_if signal set.
- Serves Renode-originated reads and writes with a configurable number of wait states and error responses.
- Flags protocol violations so co-simulation tests can detect misbehaving managers.

Parameters:
- AddressWidth, 20, width of paddr.
- DataWidth, 32, width of pwdata/prdata; must be 8, 16, 32 or 64.
- MemDepthWords, 256, number of DataWidth-bit words; the valid address range is 0 .. MemDepthWords*(DataWidth/8)-1.
- WaitStates, 0, number of access cycles with pready low before completion; range 0..15.

Ports:
- pclk  input  1  bus clock; all state updates on rising edge.
- presetn  input  1  reset, asynchronous assert, active-low.
- paddr  input  AddressWidth  byte address.
- pselx  input  1  completer select.
- penable  input  1  access phase indicator.
- pwrite  input  1  1 = write, 0 = read.
- pwdata  input  DataWidth  write data.
- pready  output  1  transfer completion.
- prdata  output  DataWidth  read data, valid when pready=1 on a read.
- pslverr  output  1  error response, valid only when pready=1.
- protocol_error  output  1  sticky violation flag.

Behaviour:
- Reset (presetn=0, asynchronous):
  - FSM goes to S_IDLE; pready=0, prdata=0, pslverr=0, protocol_error=0.
  - Memory contents are not reset.
  - Reset during S_ACCESS aborts the transfer; a pending write is discarded.
- Address decode:
  - Word index = paddr >> log2(DataWidth/8); low byte-offset bits are ignored.
  - Index >= MemDepthWords is out of range.
  - Out-of-range reads return prdata=0 with pslverr=1; out-of-range writes have no effect and return pslverr=1.
- FSM states: S_IDLE, S_ACCESS.
- S_IDLE:
  - pselx=1 & penable=0 (setup phase): latch paddr, pwrite, pwdata; load the wait counter with WaitStates; go to S_ACCESS.
  - pselx=1 & penable=1: set protocol_error=1 and remain in S_IDLE.
  - Otherwise remain in S_IDLE.
- S_ACCESS:
  - Expects pselx=1 & penable=1 on every cycle.
  - pready is low for exactly WaitStates cycles, then high for exactly one cycle.
  - With WaitStates=0, pready is high in the first access cycle, giving a 2-cycle transfer (setup + access).
  - Completion cycle (pready=1):
    - Write: the memory word is updated at the rising edge ending that cycle.
    - Read: prdata holds the memory word during that cycle.
    - pslverr reflects the range check.
    - The FSM returns to S_IDLE.
  - pselx=0 or penable=0 before completion: set protocol_error=1, abort (no write), return to S_IDLE.
  - Changes to paddr, pwrite or pwdata during access are ignored; the latched values are used.
- Back-to-back transfers:
  - A setup phase on the cycle immediately after completion is accepted, because the FSM is in S_IDLE for that cycle.
  - No idle cycle is required between transfers.
- Outputs outside the completion cycle: pready=0, pslverr=0, prdata=0.
- Outputs are registered: no combinational path from bus inputs to pready, prdata or pslverr.
- protocol_error is cleared only by reset.

Test Plan:
- WaitStates=0: write 0xDEADBEEF to 0x10, then read 0x10 -> each transfer is 2 cycles; pready high in the access cycle; read prdata=0xDEADBEEF; pslverr=0.
- WaitStates=3: read 0x0 after writing 0x12345678 -> pready low for 3 access cycles, high on the 4th; prdata=0x12345678.
- Out of range, MemDepthWords=256, DataWidth=32:
  - Write 0xFFFF to 0x400 -> pslverr=1 with pready.
  - Read 0x400 -> prdata=0, pslverr=1.
  - Read 0x3FC -> pslverr=0.
- Back-to-back: write 0x1 to 0x4, setup for read of 0x4 on the very next cycle -> read accepted without an idle cycle; prdata=0x1.
- Violation: WaitStates=2, write 0xAA to 0x8, deassert pselx in the 2nd access cycle -> protocol_error=1 (sticky); a later read of 0x8 returns the old value, not 0xAA.
- Reset mid-access: WaitStates=5, assert presetn=0 during a write to 0xC -> pready, pslverr and prdata drop to 0 immediately; memory word at 0xC unchanged; protocol_error=0.
